// File: rtl/gshare_predictor_if.sv
// Lookup/resolve port bundle for gshare_predictor. The front end (BTB and execute)
// drives the master side; the predictor sits on the slave side.
interface gshare_predictor_if #(
    parameter int unsigned TABLE_SIZE   = 1024,
    parameter int unsigned BUFFER_DEPTH = 8
);
    localparam int unsigned IDX_W   = $clog2(TABLE_SIZE);
    localparam int unsigned COUNT_W = $clog2(BUFFER_DEPTH) + 1;

    logic               predict_i;
    logic [IDX_W-1:0]   index_i;
    logic               ready_o;
    logic               prediction_o;
    logic               executed_i;
    logic               taken_i;
    logic               flush_i;
    logic               mispredicted_o;
    logic [COUNT_W-1:0] count_o;

    modport master (
        output predict_i, index_i, executed_i, taken_i, flush_i,
        input  ready_o, prediction_o, mispredicted_o, count_o
    );

    modport slave (
        input  predict_i, index_i, executed_i, taken_i, flush_i,
        output ready_o, prediction_o, mispredicted_o, count_o
    );
endinterface

// File: rtl/gshare_predictor.sv
// Gshare direction predictor: speculative history for lookup, retired history for
// recovery, saturating counter table and an in-order buffer of outstanding predictions.
module gshare_predictor #(
    parameter int unsigned TABLE_SIZE   = 1024,
    parameter int unsigned HISTORY_BITS = 10,
    parameter int unsigned COUNTER_BITS = 2,
    parameter int unsigned BUFFER_DEPTH = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    gshare_predictor_if.slave bp
);
    localparam int unsigned IDX_W   = $clog2(TABLE_SIZE);
    localparam int unsigned PTR_W   = $clog2(BUFFER_DEPTH);
    localparam int unsigned COUNT_W = PTR_W + 1;
    localparam logic [COUNTER_BITS-1:0] CNT_INIT = COUNTER_BITS'((1 << (COUNTER_BITS - 1)) - 1);

    typedef logic [HISTORY_BITS-1:0] hist_t;
    typedef logic [COUNTER_BITS-1:0] cnt_t;

    typedef struct packed {
        logic             pred;
        logic [IDX_W-1:0] idx;
    } entry_t;

    function automatic hist_t shift_hist(input hist_t h, input logic b);
        return hist_t'({h, b});
    endfunction

    // NOTE: storage arrays carry no reset; only control state is reset, so the
    // table survives rst_n_i and maps onto plain RAM.
    cnt_t   table_q [TABLE_SIZE] = '{default: CNT_INIT};
    entry_t fifo_q  [BUFFER_DEPTH];

    hist_t              spec_hist_q, spec_hist_d;
    hist_t              ret_hist_q,  ret_hist_d;
    logic [PTR_W-1:0]   wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q,    rd_ptr_d;
    logic [COUNT_W-1:0] count_q,     count_d;

    logic             full;
    logic             push;
    logic             pop;
    logic             recover;
    logic [IDX_W-1:0] hashed;
    entry_t           head;
    entry_t           push_entry;
    cnt_t             upd_cnt;
    cnt_t             upd_next;

    // ready_o looks only at the registered count, so a same-cycle pop never frees a full buffer.
    assign full         = (count_q == COUNT_W'(BUFFER_DEPTH));
    assign bp.ready_o   = !full;
    assign bp.count_o   = count_q;

    assign hashed          = bp.index_i ^ IDX_W'(spec_hist_q);
    assign bp.prediction_o = table_q[hashed][COUNTER_BITS-1];
    assign push            = bp.predict_i & !full;
    assign push_entry      = '{pred: bp.prediction_o, idx: hashed};

    assign pop               = bp.executed_i & (count_q != '0);
    assign head              = fifo_q[rd_ptr_q];
    assign bp.mispredicted_o = pop & (bp.taken_i != head.pred);
    assign recover           = bp.mispredicted_o | bp.flush_i;

    assign upd_cnt = table_q[head.idx];

    always_comb begin
        upd_next = upd_cnt;
        if (bp.taken_i) begin
            if (upd_cnt != '1) upd_next = upd_cnt + cnt_t'(1);
        end else begin
            if (upd_cnt != '0) upd_next = upd_cnt - cnt_t'(1);
        end
    end

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        spec_hist_d = spec_hist_q;
        ret_hist_d  = ret_hist_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;

        if (pop) ret_hist_d = shift_hist(ret_hist_q, bp.taken_i);

        if (recover) begin
            // Restart from the retired history including this cycle's outcome; a same-cycle push is dropped.
            spec_hist_d = ret_hist_d;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
        end else begin
            if (push) begin
                spec_hist_d = shift_hist(spec_hist_q, bp.prediction_o);
                wr_ptr_d    = wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + COUNT_W'(push) - COUNT_W'(pop);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            spec_hist_q <= '0;
            ret_hist_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            spec_hist_q <= spec_hist_d;
            ret_hist_q  <= ret_hist_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (pop) table_q[head.idx] <= upd_next;
    end

    always_ff @(posedge clk_i) begin
        if (push && !recover) fifo_q[wr_ptr_q] <= push_entry;
    end
endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor: directed vector table, hand sequences for
// full/recovery/wrap/reset corners, and random traffic against a queue-based model.
module tb_gshare_predictor;
    localparam int TABLE_SIZE   = 1024;
    localparam int HISTORY_BITS = 10;
    localparam int COUNTER_BITS = 2;
    localparam int BUFFER_DEPTH = 8;
    localparam int IDX_W        = $clog2(TABLE_SIZE);
    localparam int HMOD         = 1 << HISTORY_BITS;
    localparam int CMAX         = (1 << COUNTER_BITS) - 1;
    localparam int HALF         = 1 << (COUNTER_BITS - 1);

    logic clk_i   = 1'b0;
    logic rst_n_i = 1'b0;
    always #5 clk_i = ~clk_i;

    gshare_predictor_if #(.TABLE_SIZE(TABLE_SIZE), .BUFFER_DEPTH(BUFFER_DEPTH)) bp ();

    gshare_predictor #(
        .TABLE_SIZE  (TABLE_SIZE),
        .HISTORY_BITS(HISTORY_BITS),
        .COUNTER_BITS(COUNTER_BITS),
        .BUFFER_DEPTH(BUFFER_DEPTH)
    ) dut (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .bp     (bp)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: counters as integers, histories as integers mod 2^H, buffer as a queue.
    typedef struct {
        bit pred;
        int idx;
    } mentry_t;

    int      m_tbl[TABLE_SIZE];
    int      m_spec;
    int      m_ret;
    mentry_t m_q[$];

    typedef struct {
        bit p;
        int idx;
        bit e;
        bit t;
        bit f;
        bit ready;
        bit pred;
        bit misp;
        int count;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic bit head_pred();
        return (m_q.size() > 0) ? m_q[0].pred : 1'b0;
    endfunction

    // One clock cycle: drive at negedge, sample before the rising edge, compare, advance model.
    task automatic cycle(input bit p, input int idx, input bit e, input bit t, input bit f,
                         output bit s_ready, output bit s_pred, output bit s_misp, output int s_count);
        bit      accept;
        bit      exp_pred;
        bit      exp_misp;
        bit      pop;
        int      hashed;
        mentry_t head;
        @(negedge clk_i);
        bp.predict_i  = p;
        bp.index_i    = IDX_W'(idx);
        bp.executed_i = e;
        bp.taken_i    = t;
        bp.flush_i    = f;
        #1;
        s_ready = bp.ready_o;
        s_pred  = bp.prediction_o;
        s_misp  = bp.mispredicted_o;
        s_count = int'(bp.count_o);

        hashed   = (idx % TABLE_SIZE) ^ m_spec;
        exp_pred = (m_tbl[hashed] >= HALF);
        accept   = p && (m_q.size() < BUFFER_DEPTH);
        pop      = e && (m_q.size() > 0);
        exp_misp = 1'b0;
        if (pop) begin
            head     = m_q[0];
            exp_misp = (t != head.pred);
        end

        check("ready", int'(s_ready), int'(m_q.size() < BUFFER_DEPTH));
        check("count", s_count, m_q.size());
        if (accept) check("prediction", int'(s_pred), int'(exp_pred));
        check("mispredicted", int'(s_misp), int'(exp_misp));

        if (pop) begin
            void'(m_q.pop_front());
            if (t) m_tbl[head.idx] = (m_tbl[head.idx] == CMAX) ? CMAX : m_tbl[head.idx] + 1;
            else   m_tbl[head.idx] = (m_tbl[head.idx] == 0) ? 0 : m_tbl[head.idx] - 1;
            m_ret = ((m_ret * 2) + int'(t)) % HMOD;
        end
        if (exp_misp || f) begin
            m_q.delete();
            m_spec = m_ret;
        end else if (accept) begin
            m_q.push_back('{pred: exp_pred, idx: hashed});
            m_spec = ((m_spec * 2) + int'(exp_pred)) % HMOD;
        end
    endtask

    task automatic step(input bit p, input int idx, input bit e, input bit t, input bit f);
        bit r, pr, mi;
        int c;
        cycle(p, idx, e, t, f, r, pr, mi, c);
    endtask

    task automatic resolve_ok();
        step(1'b0, 0, 1'b1, head_pred(), 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < BUFFER_DEPTH; i++) if (m_q.size() > 0) resolve_ok();
    endtask

    initial begin
        bit r, pr, mi;
        int c;

        foreach (m_tbl[i]) m_tbl[i] = HALF - 1;
        m_spec = 0;
        m_ret  = 0;

        bp.predict_i  = 1'b0;
        bp.index_i    = '0;
        bp.executed_i = 1'b0;
        bp.taken_i    = 1'b0;
        bp.flush_i    = 1'b0;

        #1;
        check("rst_count", int'(bp.count_o), 0);
        check("rst_ready", int'(bp.ready_o), 1);
        check("rst_misp", int'(bp.mispredicted_o), 0);
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;

        // {p, idx, e, t, f, ready, pred, misp, count-before-edge}; fresh table is all weakly-not-taken.
        vecs[0]  = '{1'b0, 'h000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0}; // resolve while empty: ignored
        vecs[1]  = '{1'b1, 'h020, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        vecs[2]  = '{1'b0, 'h000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1}; // 01 -> 00
        vecs[3]  = '{1'b1, 'h020, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        vecs[4]  = '{1'b0, 'h000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1}; // 00 stays 00
        vecs[5]  = '{1'b1, 'h020, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        vecs[6]  = '{1'b0, 'h000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1}; // 00 stays 00
        vecs[7]  = '{1'b1, 'h020, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0}; // wrapping counter would predict 1
        vecs[8]  = '{1'b0, 'h000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        vecs[9]  = '{1'b1, 'h005, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        vecs[10] = '{1'b0, 'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1}; // count 1 after accept
        vecs[11] = '{1'b0, 'h000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        vecs[12] = '{1'b1, 'h010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        vecs[13] = '{1'b0, 'h000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1}; // mispredict, 01 -> 10
        vecs[14] = '{1'b0, 'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        vecs[15] = '{1'b1, 'h011, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0}; // hist 1: hashes to 0x010
        vecs[16] = '{1'b0, 'h000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        vecs[17] = '{1'b0, 'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        vecs[18] = '{1'b1, 'h020, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0}; // hist 3 -> entry 0x023, fresh 01

        foreach (vecs[i]) begin
            cycle(vecs[i].p, vecs[i].idx, vecs[i].e, vecs[i].t, vecs[i].f, r, pr, mi, c);
            check($sformatf("vec%0d_ready", i), int'(r), int'(vecs[i].ready));
            check($sformatf("vec%0d_count", i), c, vecs[i].count);
            check($sformatf("vec%0d_misp", i), int'(mi), int'(vecs[i].misp));
            if (vecs[i].p) check($sformatf("vec%0d_pred", i), int'(pr), int'(vecs[i].pred));
        end
        drain();

        // Fill to full, then a refused predict, then one correct resolve.
        for (int i = 0; i < BUFFER_DEPTH; i++) step(1'b1, int'($urandom_range(0, TABLE_SIZE - 1)), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 'h155, 1'b0, 1'b0, 1'b0, r, pr, mi, c);
        check("full_ready", int'(r), 0);
        check("full_count", c, BUFFER_DEPTH);
        cycle(1'b1, 'h0aa, 1'b1, head_pred(), 1'b0, r, pr, mi, c);
        check("full_pop_push_ready", int'(r), 0);
        cycle(1'b0, 0, 1'b0, 1'b0, 1'b0, r, pr, mi, c);
        check("after_pop_count", c, BUFFER_DEPTH - 1);
        check("after_pop_ready", int'(r), 1);
        drain();

        // Mispredict on a head predicted not-taken while pushing.
        step(1'b1, 'h020 ^ m_spec, 1'b0, 1'b0, 1'b0);
        check("mp_head_pred", int'(m_q[0].pred), 0);
        step(1'b1, int'($urandom_range(0, TABLE_SIZE - 1)), 1'b0, 1'b0, 1'b0);
        step(1'b1, int'($urandom_range(0, TABLE_SIZE - 1)), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 'h077, 1'b1, 1'b1, 1'b0, r, pr, mi, c);
        check("mp_misp", int'(mi), 1);
        check("mp_count_before", c, 3);
        cycle(1'b1, 'h033, 1'b0, 1'b0, 1'b0, r, pr, mi, c);
        check("mp_count_after", c, 0);
        drain();

        // Steady push+pop at count 4 for three laps of the buffer.
        for (int i = 0; i < 4; i++) step(1'b1, int'($urandom_range(0, TABLE_SIZE - 1)), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3 * BUFFER_DEPTH; i++)
            step(1'b1, int'($urandom_range(0, TABLE_SIZE - 1)), 1'b1, head_pred(), 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b0, 1'b0, r, pr, mi, c);
        check("lap_count", c, 4);
        drain();

        // External flush with five outstanding.
        for (int i = 0; i < 5; i++) step(1'b1, int'($urandom_range(0, TABLE_SIZE - 1)), 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b0, 1'b1, r, pr, mi, c);
        check("flush_count_before", c, 5);
        cycle(1'b1, 'h123, 1'b0, 1'b0, 1'b0, r, pr, mi, c);
        check("flush_count_after", c, 0);
        drain();

        // Random traffic, biased toward correct resolves so the buffer fills.
        for (int i = 0; i < 3000; i++) begin
            bit p, e, t, f;
            int idx;
            p   = ($urandom_range(0, 3) != 0);
            e   = ($urandom_range(0, 2) == 0);
            t   = ($urandom_range(0, 9) < 8) ? head_pred() : ~head_pred();
            f   = ($urandom_range(0, 63) == 0);
            idx = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, TABLE_SIZE - 1));
            step(p, idx, e, t, f);
        end

        // Asynchronous reset mid-run; table contents must survive.
        for (int i = 0; i < 3; i++) step(1'b1, int'($urandom_range(0, TABLE_SIZE - 1)), 1'b0, 1'b0, 1'b0);
        @(negedge clk_i);
        bp.predict_i  = 1'b0;
        bp.executed_i = 1'b1;
        bp.taken_i    = 1'b1;
        #2;
        rst_n_i = 1'b0;
        #1;
        check("async_rst_count", int'(bp.count_o), 0);
        check("async_rst_ready", int'(bp.ready_o), 1);
        check("async_rst_misp", int'(bp.mispredicted_o), 0);
        bp.executed_i = 1'b0;
        bp.taken_i    = 1'b0;
        m_q.delete();
        m_spec = 0;
        m_ret  = 0;
        @(negedge clk_i);
        rst_n_i = 1'b1;

        for (int i = 0; i < 500; i++) begin
            bit p, e, t;
            p = ($urandom_range(0, 1) != 0);
            e = ($urandom_range(0, 2) == 0);
            t = ($urandom_range(0, 9) < 7) ? head_pred() : ~head_pred();
            step(p, int'($urandom_range(0, 31)), e, t, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
